// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode definitions: opcodes, control-word layout, field encodings
// and the decoded-entry payload held in the decode_stage storage registers.
package rv_decode_pkg;

   localparam int unsigned MAX_XLEN  = 64;
   localparam int unsigned MAX_TAG_W = 64;
   localparam int unsigned CTRL_W    = 18;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam int unsigned CTRL_ALU_FN   = 15;
   localparam int unsigned CTRL_ALU_ALT  = 14;
   localparam int unsigned CTRL_A_SEL    = 12;
   localparam int unsigned CTRL_B_SEL    = 10;
   localparam int unsigned CTRL_REG_WE   = 9;
   localparam int unsigned CTRL_WB_SEL   = 7;
   localparam int unsigned CTRL_MEM_WE   = 6;
   localparam int unsigned CTRL_MEM_RE   = 5;
   localparam int unsigned CTRL_IMM_TYPE = 2;
   localparam int unsigned CTRL_BRANCH   = 1;
   localparam int unsigned CTRL_JUMP     = 0;

   localparam logic [CTRL_W-1:0] NOP_CTRL = '0;

   localparam logic [1:0] A_RS1  = 2'b00;
   localparam logic [1:0] A_PC   = 2'b01;
   localparam logic [1:0] A_ZERO = 2'b10;

   localparam logic [1:0] B_RS2  = 2'b00;
   localparam logic [1:0] B_IMM  = 2'b01;
   localparam logic [1:0] B_FOUR = 2'b10;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   localparam logic [2:0] IMM_NONE = 3'b000;
   localparam logic [2:0] IMM_I    = 3'b001;
   localparam logic [2:0] IMM_S    = 3'b010;
   localparam logic [2:0] IMM_B    = 3'b011;
   localparam logic [2:0] IMM_U    = 3'b100;
   localparam logic [2:0] IMM_J    = 3'b101;

   // Sized for the widest configuration; the stage slices to XLEN/TAG_W at its ports.
   typedef struct packed {
      logic [CTRL_W-1:0]    ctrl;
      logic [MAX_XLEN-1:0]  imm;
      logic [4:0]           rs1;
      logic [4:0]           rs2;
      logic [4:0]           rd;
      logic [MAX_TAG_W-1:0] tag;
      logic                 illegal;
      logic                 muldiv;
   } dec_entry_t;

endpackage

// File: rtl/rv_decode_comb.sv
// Purely combinational RV32I decoder producing one decoded entry per instruction.
// RV_MEXT_EN makes OP/funct7=0000001 (M extension) legal and flags it as muldiv.
module rv_decode_comb
   import rv_decode_pkg::*;
#(
   parameter int unsigned TAG_W = 32
) (
   input  logic [31:0]      inst,
   input  logic [TAG_W-1:0] tag,
   output dec_entry_t       entry
);

   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic [2:0]        imm_type;
   logic [31:0]       imm32;
   logic [CTRL_W-1:0] ctrl;
   logic              illegal;
   logic              muldiv;

   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];
   assign funct7 = inst[31:25];

   // Control word and legality; any illegal encoding collapses to NOP.
   always_comb begin
      ctrl     = NOP_CTRL;
      imm_type = IMM_NONE;
      illegal  = 1'b0;
      muldiv   = 1'b0;
      case (opcode)
         OPC_LUI: begin
            ctrl[CTRL_A_SEL +: 2]  = A_ZERO;
            ctrl[CTRL_B_SEL +: 2]  = B_IMM;
            ctrl[CTRL_REG_WE]      = 1'b1;
            ctrl[CTRL_WB_SEL +: 2] = WB_ALU;
            imm_type               = IMM_U;
         end
         OPC_AUIPC: begin
            ctrl[CTRL_A_SEL +: 2] = A_PC;
            ctrl[CTRL_B_SEL +: 2] = B_IMM;
            ctrl[CTRL_REG_WE]     = 1'b1;
            imm_type              = IMM_U;
         end
         OPC_JAL: begin
            ctrl[CTRL_A_SEL +: 2]  = A_PC;
            ctrl[CTRL_B_SEL +: 2]  = B_IMM;
            ctrl[CTRL_REG_WE]      = 1'b1;
            ctrl[CTRL_WB_SEL +: 2] = WB_PC4;
            ctrl[CTRL_JUMP]        = 1'b1;
            imm_type               = IMM_J;
         end
         OPC_JALR: begin
            ctrl[CTRL_A_SEL +: 2]  = A_RS1;
            ctrl[CTRL_B_SEL +: 2]  = B_IMM;
            ctrl[CTRL_REG_WE]      = 1'b1;
            ctrl[CTRL_WB_SEL +: 2] = WB_PC4;
            ctrl[CTRL_JUMP]        = 1'b1;
            imm_type               = IMM_I;
            illegal                = (funct3 != 3'b000);
         end
         OPC_BRANCH: begin
            ctrl[CTRL_B_SEL +: 2] = B_RS2;
            ctrl[CTRL_BRANCH]     = 1'b1;
            imm_type              = IMM_B;
            illegal               = (funct3 == 3'b010) || (funct3 == 3'b011);
         end
         OPC_LOAD: begin
            ctrl[CTRL_B_SEL +: 2]  = B_IMM;
            ctrl[CTRL_REG_WE]      = 1'b1;
            ctrl[CTRL_WB_SEL +: 2] = WB_MEM;
            ctrl[CTRL_MEM_RE]      = 1'b1;
            imm_type               = IMM_I;
            illegal                = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
         end
         OPC_STORE: begin
            ctrl[CTRL_B_SEL +: 2] = B_IMM;
            ctrl[CTRL_MEM_WE]     = 1'b1;
            imm_type              = IMM_S;
            illegal               = (funct3 > 3'b010);
         end
         OPC_OP_IMM: begin
            ctrl[CTRL_ALU_FN +: 3] = funct3;
            ctrl[CTRL_B_SEL +: 2]  = B_IMM;
            ctrl[CTRL_REG_WE]      = 1'b1;
            imm_type               = IMM_I;
            if (funct3 == 3'b001) begin
               illegal = (funct7 != 7'b0000000);
            end else if (funct3 == 3'b101) begin
               ctrl[CTRL_ALU_ALT] = (funct7 == 7'b0100000);
               illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end
         end
         OPC_OP: begin
            ctrl[CTRL_ALU_FN +: 3] = funct3;
            ctrl[CTRL_B_SEL +: 2]  = B_RS2;
            ctrl[CTRL_REG_WE]      = 1'b1;
            if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
               ctrl[CTRL_ALU_ALT] = 1'b1;
            end else if (funct7 == 7'b0000001) begin
`ifdef RV_MEXT_EN
               muldiv = 1'b1;
`else
               illegal = 1'b1;
`endif
            end else if (funct7 != 7'b0000000) begin
               illegal = 1'b1;
            end
         end
         OPC_FENCE, OPC_SYSTEM: ctrl = NOP_CTRL;
         default: illegal = 1'b1;
      endcase
      ctrl[CTRL_IMM_TYPE +: 3] = imm_type;
      if (illegal) begin
         ctrl     = NOP_CTRL;
         imm_type = IMM_NONE;
         muldiv   = 1'b0;
      end
   end

   always_comb begin
      case (imm_type)
         IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
         IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         IMM_U:   imm32 = {inst[31:12], 12'b0};
         IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   always_comb begin
      entry.ctrl    = ctrl;
      entry.imm     = MAX_XLEN'($signed(imm32));
      entry.rs1     = inst[19:15];
      entry.rs2     = inst[24:20];
      entry.rd      = inst[11:7];
      entry.tag     = MAX_TAG_W'(tag);
      entry.illegal = illegal;
      entry.muldiv  = muldiv;
   end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with a two-entry skid buffer (head + skid).
// RV_MEXT_EN enables M-extension decode and drives out_muldiv.
module decode_stage
   import rv_decode_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 32
) (
   input  logic             in_clk,
   input  logic             in_rst_n,
   input  logic             in_flush,
   input  logic             in_valid,
   output logic             out_ready,
   input  logic [31:0]      in_inst,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             in_ready,
   output logic [17:0]      out_ctrl,
   output logic [XLEN-1:0]  out_imm,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [4:0]       out_rd,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal,
   output logic             out_muldiv
);

   dec_entry_t dec;
   dec_entry_t head_q;
   dec_entry_t skid_q;
   logic       head_valid;
   logic       skid_valid;
   logic       accept;
   logic       pop;
   logic       unused_bits;

   rv_decode_comb #(.TAG_W(TAG_W)) u_dec (
      .inst  (in_inst),
      .tag   (in_tag),
      .entry (dec)
   );

   assign out_ready = in_rst_n & ~skid_valid;
   assign accept    = in_valid & out_ready;
   assign pop       = head_valid & in_ready;

   // Skid only fills while the head is held, so out_ready = !skid_valid keeps it lossless.
   always_ff @(posedge in_clk) begin
      if (!in_rst_n) begin
         head_valid <= 1'b0;
         skid_valid <= 1'b0;
         head_q     <= '0;
         skid_q     <= '0;
      end else if (in_flush) begin
         head_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (pop && skid_valid) begin
         head_q     <= skid_q;
         skid_valid <= 1'b0;
      end else if (pop || !head_valid) begin
         head_valid <= accept;
         if (accept) head_q <= dec;
      end else if (accept) begin
         skid_q     <= dec;
         skid_valid <= 1'b1;
      end
   end

   assign out_valid   = head_valid;
   assign out_ctrl    = head_q.ctrl;
   assign out_imm     = head_q.imm[XLEN-1:0];
   assign out_rs1     = head_q.rs1;
   assign out_rs2     = head_q.rs2;
   assign out_rd      = head_q.rd;
   assign out_tag     = head_q.tag[TAG_W-1:0];
   assign out_illegal = head_q.illegal;
`ifdef RV_MEXT_EN
   assign out_muldiv  = head_q.muldiv;
`else
   assign out_muldiv  = 1'b0;
`endif

   // Upper imm/tag bits beyond the configured widths are intentionally dropped.
   assign unused_bits = ^{head_q.imm, head_q.tag, head_q.muldiv};

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized stream
// scored against a queue-based model with an independent arithmetic decoder.
module tb_decode_stage;

   logic        in_clk = 1'b0;
   logic        in_rst_n;
   logic        in_flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_inst;
   logic [31:0] in_tag;
   logic        out_valid;
   logic        in_ready;
   logic [17:0] out_ctrl;
   logic [31:0] out_imm;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [4:0]  out_rd;
   logic [31:0] out_tag;
   logic        out_illegal;
   logic        out_muldiv;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [17:0] ctrl;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] tag;
      logic        illegal;
      logic        muldiv;
   } exp_t;

   exp_t q[$];

   always #5 in_clk = ~in_clk;

   decode_stage #(.XLEN(32), .TAG_W(32)) dut (
      .in_clk      (in_clk),
      .in_rst_n    (in_rst_n),
      .in_flush    (in_flush),
      .in_valid    (in_valid),
      .out_ready   (out_ready),
      .in_inst     (in_inst),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .in_ready    (in_ready),
      .out_ctrl    (out_ctrl),
      .out_imm     (out_imm),
      .out_rs1     (out_rs1),
      .out_rs2     (out_rs2),
      .out_rd      (out_rd),
      .out_tag     (out_tag),
      .out_illegal (out_illegal),
      .out_muldiv  (out_muldiv)
   );

   function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] tag);
      exp_t e;
      int s, op, f3, f7, v, c;
      int alu_fn, alt, asel, bsel, we, wb, mw, mr, it, br, jp;
      bit bad, md;
      s = $signed(inst);
      op = int'(inst[6:0]);
      f3 = int'(inst[14:12]);
      f7 = int'(inst[31:25]);
      alu_fn = 0; alt = 0; asel = 0; bsel = 0; we = 0; wb = 0;
      mw = 0; mr = 0; it = 0; br = 0; jp = 0; bad = 1'b0; md = 1'b0;
      case (op)
         'h37: begin asel = 2; bsel = 1; we = 1; it = 4; end
         'h17: begin asel = 1; bsel = 1; we = 1; it = 4; end
         'h6F: begin asel = 1; bsel = 1; we = 1; wb = 2; it = 5; jp = 1; end
         'h67: begin bsel = 1; we = 1; wb = 2; it = 1; jp = 1; bad = (f3 != 0); end
         'h63: begin it = 3; br = 1; bad = (f3 == 2 || f3 == 3); end
         'h03: begin bsel = 1; we = 1; wb = 1; mr = 1; it = 1; bad = (f3 == 3 || f3 >= 6); end
         'h23: begin bsel = 1; mw = 1; it = 2; bad = (f3 > 2); end
         'h13: begin
            alu_fn = f3; bsel = 1; we = 1; it = 1;
            if (f3 == 1) bad = (f7 != 0);
            else if (f3 == 5) begin
               bad = !(f7 == 0 || f7 == 32);
               alt = (f7 == 32) ? 1 : 0;
            end
         end
         'h33: begin
            alu_fn = f3; we = 1;
            if (f7 == 32 && (f3 == 0 || f3 == 5)) alt = 1;
`ifdef RV_MEXT_EN
            else if (f7 == 1) md = 1'b1;
`endif
            else if (f7 != 0) bad = 1'b1;
         end
         'h0F, 'h73: ;
         default: bad = 1'b1;
      endcase
      case (it)
         1: v = s >>> 20;
         2: v = ((s >>> 25) << 5) | int'(inst[11:7]);
         3: v = ((s >>> 31) << 12) | (int'(inst[7]) << 11) | (int'(inst[30:25]) << 5) | (int'(inst[11:8]) << 1);
         4: v = int'(inst & 32'hFFFFF000);
         5: v = ((s >>> 31) << 20) | (int'(inst[19:12]) << 12) | (int'(inst[20]) << 11) | (int'(inst[30:21]) << 1);
         default: v = 0;
      endcase
      c = (alu_fn << 15) | (alt << 14) | (asel << 12) | (bsel << 10) | (we << 9) | (wb << 7)
        | (mw << 6) | (mr << 5) | (it << 2) | (br << 1) | jp;
      if (bad) begin c = 0; v = 0; md = 1'b0; end
      e.ctrl = 18'(c);
      e.imm = v;
      e.rs1 = inst[19:15];
      e.rs2 = inst[24:20];
      e.rd = inst[11:7];
      e.tag = tag;
      e.illegal = bad;
      e.muldiv = md;
      return e;
   endfunction

   // Apply inputs at a negedge, advance the model across the next posedge, return at the next negedge.
   task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] tag,
                        input logic rdy, input logic fl);
      bit can_take, do_pop, do_acc;
      in_valid = v; in_inst = inst; in_tag = tag; in_ready = rdy; in_flush = fl;
      if (!in_rst_n || fl) q.delete();
      else begin
         can_take = (q.size() < 2);
         do_pop = (q.size() > 0) && rdy;
         do_acc = v && can_take;
         if (do_pop) void'(q.pop_front());
         if (do_acc) q.push_back(ref_decode(inst, tag));
      end
      @(negedge in_clk);
   endtask

   task automatic drain();
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic test_reset();
      in_rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 32'h123450B7, 32'h55, 1'b1, 1'b0);
         n_checks++;
         if ({out_valid, out_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_handshake: valid/ready=%b required 00", {out_valid, out_ready});
         end
         n_checks++;
         if ({out_ctrl, out_imm, out_rs1, out_rs2, out_rd, out_tag, out_illegal, out_muldiv} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ctrl=%h imm=%h rd=%h tag=%h ill=%b md=%b required all 0",
                     out_ctrl, out_imm, out_rd, out_tag, out_illegal, out_muldiv);
         end
      end
      in_rst_n = 1'b1;
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      n_checks++;
      if (out_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: ready=%b valid=%b required 1 0", out_ready, out_valid);
      end
   endtask

   task automatic test_lui();
      cycle(1'b1, 32'h123450B7, 32'h100, 1'b1, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || out_ctrl !== 18'h02610 || out_imm !== 32'h12345000) begin
         n_fail++;
         $display("FAIL lui_decode: valid=%b ctrl=%h imm=%h required 1 02610 12345000", out_valid, out_ctrl, out_imm);
      end
      n_checks++;
      if (out_rd !== 5'd1 || out_tag !== 32'h100 || out_illegal !== 1'b0) begin
         n_fail++;
         $display("FAIL lui_fields: rd=%0d tag=%h ill=%b required 1 100 0", out_rd, out_tag, out_illegal);
      end
      drain();
   endtask

   task automatic test_beq();
      cycle(1'b1, 32'hFE000EE3, 32'h200, 1'b1, 1'b0);
      n_checks++;
      if (out_imm !== 32'hFFFFFFFC || out_ctrl[1] !== 1'b1 || out_ctrl[4:2] !== 3'b011 || out_illegal !== 1'b0) begin
         n_fail++;
         $display("FAIL beq_decode: imm=%h branch=%b imm_type=%b ill=%b required FFFFFFFC 1 011 0",
                  out_imm, out_ctrl[1], out_ctrl[4:2], out_illegal);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      cycle(1'b1, 32'h00100093, 32'hA0, 1'b0, 1'b0);
      cycle(1'b1, 32'h00200113, 32'hA4, 1'b0, 1'b0);
      cycle(1'b1, 32'h00300193, 32'hA8, 1'b0, 1'b0);
      n_checks++;
      if (out_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 32'hA0) begin
         n_fail++;
         $display("FAIL bp_full: ready=%b valid=%b tag=%h required 0 1 A0", out_ready, out_valid, out_tag);
      end
      cycle(1'b1, 32'h00300193, 32'hA8, 1'b1, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || out_tag !== 32'hA4 || out_rd !== 5'd2) begin
         n_fail++;
         $display("FAIL bp_second: valid=%b tag=%h rd=%0d required 1 A4 2", out_valid, out_tag, out_rd);
      end
      cycle(1'b1, 32'h00300193, 32'hA8, 1'b1, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || out_tag !== 32'hA8 || out_imm !== 32'd3) begin
         n_fail++;
         $display("FAIL bp_third: valid=%b tag=%h imm=%h required 1 A8 3", out_valid, out_tag, out_imm);
      end
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      n_checks++;
      if (out_valid !== 1'b0 || out_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_empty: valid=%b ready=%b required 0 1", out_valid, out_ready);
      end
   endtask

   task automatic test_illegal_flush();
      cycle(1'b1, 32'h0000000B, 32'h300, 1'b1, 1'b0);
      n_checks++;
      if (out_illegal !== 1'b1 || out_ctrl !== 18'h0 || out_imm !== 32'h0 || out_tag !== 32'h300) begin
         n_fail++;
         $display("FAIL illegal_opcode: ill=%b ctrl=%h imm=%h tag=%h required 1 0 0 300", out_illegal, out_ctrl, out_imm, out_tag);
      end
      drain();
      cycle(1'b1, 32'h00500293, 32'h10, 1'b0, 1'b0);
      cycle(1'b1, 32'h00600313, 32'h14, 1'b0, 1'b0);
      cycle(1'b1, 32'h00700393, 32'h18, 1'b0, 1'b1);
      n_checks++;
      if (out_valid !== 1'b0 || out_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_clear: valid=%b ready=%b required 0 1", out_valid, out_ready);
      end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_nothing_delivered: valid=%b tag=%h required 0", out_valid, out_tag);
         end
      end
   endtask

   task automatic test_mul();
      cycle(1'b1, 32'h022081B3, 32'h400, 1'b1, 1'b0);
`ifdef RV_MEXT_EN
      n_checks++;
      if (out_muldiv !== 1'b1 || out_illegal !== 1'b0 || out_rd !== 5'd3 || out_ctrl !== 18'h00200) begin
         n_fail++;
         $display("FAIL mul_mext: md=%b ill=%b rd=%0d ctrl=%h required 1 0 3 00200", out_muldiv, out_illegal, out_rd, out_ctrl);
      end
`else
      n_checks++;
      if (out_illegal !== 1'b1 || out_muldiv !== 1'b0 || out_ctrl !== 18'h0 || out_rd !== 5'd3) begin
         n_fail++;
         $display("FAIL mul_no_mext: ill=%b md=%b ctrl=%h rd=%0d required 1 0 0 3", out_illegal, out_muldiv, out_ctrl, out_rd);
      end
`endif
      drain();
   endtask

   task automatic test_reset_midstream();
      cycle(1'b1, 32'h00100093, 32'h1, 1'b0, 1'b0);
      cycle(1'b1, 32'h00200113, 32'h2, 1'b0, 1'b0);
      in_rst_n = 1'b0;
      cycle(1'b1, 32'h00300193, 32'h3, 1'b1, 1'b0);
      n_checks++;
      if (out_valid !== 1'b0 || out_ready !== 1'b0 || out_ctrl !== 18'h0 || out_tag !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_midstream: valid=%b ready=%b ctrl=%h tag=%h required 0 0 0 0", out_valid, out_ready, out_ctrl, out_tag);
      end
      in_rst_n = 1'b1;
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      n_checks++;
      if (out_valid !== 1'b0 || out_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_midstream_release: valid=%b ready=%b required 0 1", out_valid, out_ready);
      end
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 9) != 0) begin
         case ($urandom_range(0, 10))
            0: w[6:0] = 7'h37;  1: w[6:0] = 7'h17;  2: w[6:0] = 7'h6F;
            3: w[6:0] = 7'h67;  4: w[6:0] = 7'h63;  5: w[6:0] = 7'h03;
            6: w[6:0] = 7'h23;  7: w[6:0] = 7'h13;  8: w[6:0] = 7'h33;
            9: w[6:0] = 7'h0F;  default: w[6:0] = 7'h73;
         endcase
      end
      if ($urandom_range(0, 2) != 0) begin
         case ($urandom_range(0, 2))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: w[31:25] = 7'h01;
         endcase
      end
      return w;
   endfunction

   task automatic test_random();
      exp_t e;
      logic ev;
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 9) < 7), rand_inst(), $urandom, ($urandom_range(0, 9) < 6),
               ($urandom_range(0, 49) == 0));
         ev = (q.size() != 0);
         n_checks++;
         if (out_valid !== ev || out_ready !== (q.size() < 2)) begin
            n_fail++;
            $display("FAIL rand_handshake cyc %0d: valid=%b ready=%b required %b %b", i, out_valid, out_ready, ev, (q.size() < 2));
         end
         if (ev) begin
            e = q[0];
            n_checks++;
            if ({out_ctrl, out_imm, out_rs1, out_rs2, out_rd, out_tag, out_illegal, out_muldiv} !== e) begin
               n_fail++;
               $display("FAIL rand_entry cyc %0d: got ctrl=%h imm=%h rs1=%0d rs2=%0d rd=%0d tag=%h ill=%b md=%b required ctrl=%h imm=%h rs1=%0d rs2=%0d rd=%0d tag=%h ill=%b md=%b",
                        i, out_ctrl, out_imm, out_rs1, out_rs2, out_rd, out_tag, out_illegal, out_muldiv,
                        e.ctrl, e.imm, e.rs1, e.rs2, e.rd, e.tag, e.illegal, e.muldiv);
            end
         end
      end
      drain();
   endtask

   initial begin
      in_rst_n = 1'b0;
      in_flush = 1'b0;
      in_valid = 1'b1;
      in_inst  = 32'h0;
      in_tag   = 32'h0;
      in_ready = 1'b1;
      test_reset();
      test_lui();
      test_beq();
      test_back_to_back();
      test_illegal_flush();
      test_mul();
      test_reset_midstream();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
